// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
//
// 640x480 @ 60 Hz VGA timing generator running from a 100 MHz clock.
// A 2-bit divider produces a one-clk pixel strobe every 4 clk. Horizontal and
// vertical counters advance on that strobe. Both syncs are registered so they
// switch on the same edge as the counters.
//
// Ports
//   clk          : system clock, sole clock
//   reset        : synchronous, active-high reset
//   p_tick       : pixel-enable strobe, high when the divider reads 3
//   pixel_x      : horizontal count, 0..799
//   pixel_y      : vertical count, 0..524
//   hsync        : horizontal sync, active-low, low for h in 656..751
//   vsync        : vertical sync, active-low, low for v in 490..491
//   video_on_out : high inside the 640x480 visible area
//   frame_tick   : one-clk pulse on the strobe where both counters wrap
//   blink        : cursor blink square wave
//
// Build option
//   VGA_TIMING_BLINK_EN : when defined, blink toggles every 30 frames.
//                         When undefined, blink is tied to 0.
//
// The timing parameters default to standard 640x480 timing. They can be
// overridden to shrink the raster, for example to make a small test raster.
// -----------------------------------------------------------------------------
module vga_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on_out,
    output logic       frame_tick,
    output logic       blink
);

    localparam int         H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int         V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] H_MAX        = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX        = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [1:0] div_reg;
    logic [9:0] h_reg;
    logic [9:0] h_next;
    logic [9:0] v_reg;
    logic [9:0] v_next;
    logic       hsync_reg;
    logic       hsync_next;
    logic       vsync_reg;
    logic       vsync_next;

    assign p_tick = (div_reg == 2'd3);

    // Next counter values. The syncs are decoded from these next values so
    // that the registered syncs line up with the counters they describe.
    always_comb begin
        h_next = h_reg;
        v_next = v_reg;
        if (p_tick) begin
            if (h_reg == H_MAX) begin
                h_next = 10'd0;
                if (v_reg == V_MAX) begin
                    v_next = 10'd0;
                end else begin
                    v_next = v_reg + 10'd1;
                end
            end else begin
                h_next = h_reg + 10'd1;
            end
        end
        hsync_next = !((h_next >= H_SYNC_FIRST) && (h_next <= H_SYNC_LAST));
        vsync_next = !((v_next >= V_SYNC_FIRST) && (v_next <= V_SYNC_LAST));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg   <= 2'd0;
            h_reg     <= 10'd0;
            v_reg     <= 10'd0;
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
        end else begin
            div_reg   <= div_reg + 2'd1;
            h_reg     <= h_next;
            v_reg     <= v_next;
            hsync_reg <= hsync_next;
            vsync_reg <= vsync_next;
        end
    end

    assign pixel_x      = h_reg;
    assign pixel_y      = v_reg;
    assign hsync        = hsync_reg;
    assign vsync        = vsync_reg;
    assign video_on_out = (h_reg < H_VIS_END) && (v_reg < V_VIS_END);
    assign frame_tick   = p_tick && (h_reg == H_MAX) && (v_reg == V_MAX);

`ifdef VGA_TIMING_BLINK_EN
    // Frame counter 0..29; blink flips on the frame_tick that wraps it,
    // so each blink level lasts 30 frames.
    localparam logic [4:0] FRAME_LAST = 5'd29;

    logic [4:0] frame_cnt_reg;
    logic       blink_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_reg <= 5'd0;
            blink_reg     <= 1'b0;
        end else if (frame_tick) begin
            if (frame_cnt_reg == FRAME_LAST) begin
                frame_cnt_reg <= 5'd0;
                blink_reg     <= ~blink_reg;
            end else begin
                frame_cnt_reg <= frame_cnt_reg + 5'd1;
            end
        end
    end

    assign blink = blink_reg;
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing
//
// Two instances share one clock: dut_a uses full 640x480 timing for the
// divider, horizontal and reset behaviour, and dut_b uses a shrunken raster
// (12x10 pixels) so that vertical sync, frame wrap and 61-frame blink
// behaviour fit in a short run. Expected outputs come from a closed-form model.
// In that model, k clocks after reset release give pixel index k/4. That index
// is split into h, line and frame with divide/modulo, and each output is
// decoded from those values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1;
    logic       pt_a, hs_a, vs_a, vid_a, ft_a, bl_a;
    logic [9:0] x_a, y_a;
    logic       rst_b = 1'b1;
    logic       pt_b, hs_b, vs_b, vid_b, ft_b, bl_b;
    logic [9:0] x_b, y_b;

    vga_timing dut_a (
        .clk(clk), .reset(rst_a), .p_tick(pt_a), .pixel_x(x_a), .pixel_y(y_a),
        .hsync(hs_a), .vsync(vs_a), .video_on_out(vid_a), .frame_tick(ft_a), .blink(bl_a)
    );

    vga_timing #(
        .H_VISIBLE(6), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(5), .V_FRONT(2), .V_SYNC(1), .V_BACK(2)
    ) dut_b (
        .clk(clk), .reset(rst_b), .p_tick(pt_b), .pixel_x(x_b), .pixel_y(y_b),
        .hsync(hs_b), .vsync(vs_b), .video_on_out(vid_b), .frame_tick(ft_b), .blink(bl_b)
    );

    // Packed observation: {p_tick, frame_tick, hsync, vsync, video_on, blink, x, y}
    wire [25:0] obs_a = {pt_a, ft_a, hs_a, vs_a, vid_a, bl_a, x_a, y_a};
    wire [25:0] obs_b = {pt_b, ft_b, hs_b, vs_b, vid_b, bl_b, x_b, y_b};

    int n_cmp = 0;
    int n_bad = 0;
    int ka = 0;
    int kb = 0;

    // Reference model: outputs k clocks after reset release.
    function automatic logic [25:0] model(input int k, input int hv, input int hf, input int hs,
                                          input int hb, input int vv, input int vf, input int vs,
                                          input int vb);
        int  ht, vt, pix, h, line, v, frames;
        logic pt, ft, hsn, vsn, vid, bl;
        ht     = hv + hf + hs + hb;
        vt     = vv + vf + vs + vb;
        pix    = k / 4;
        h      = pix % ht;
        line   = pix / ht;
        v      = line % vt;
        frames = line / vt;
        pt     = (k % 4) == 3;
        ft     = pt && (h == ht - 1) && (v == vt - 1);
        hsn    = !((h >= hv + hf) && (h < hv + hf + hs));
        vsn    = !((v >= vv + vf) && (v < vv + vf + vs));
        vid    = (h < hv) && (v < vv);
`ifdef VGA_TIMING_BLINK_EN
        bl     = ((frames / 30) % 2) == 1;
`else
        bl     = 1'b0;
`endif
        return {pt, ft, hsn, vsn, vid, bl, 10'(h), 10'(v)};
    endfunction

    function automatic logic [25:0] fa(input int k);
        return model(k, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic logic [25:0] fb(input int k);
        return model(k, 6, 2, 2, 2, 5, 2, 1, 2);
    endfunction

    task automatic tick_a();
        @(posedge clk);
        ka++;
        @(negedge clk);
    endtask

    task automatic tick_b();
        @(posedge clk);
        kb++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int cyc;
        cyc = int'($urandom_range(1, 5));
        @(negedge clk);
        rst_a = 1'b1;
        repeat (cyc) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (obs_a !== fa(0)) begin
            n_bad++;
            $display("FAIL reset_state got=%h exp=%h", obs_a, fa(0));
        end
        rst_a = 1'b0;
        ka = 0;
        $display("test_reset: reset held %0d clk, state checked", cyc);
    endtask

    task automatic test_divider();
        for (int i = 0; i < 12; i++) begin
            tick_a();
            n_cmp++;
            if (obs_a !== fa(ka)) begin
                n_bad++;
                $display("FAIL divider k=%0d got=%h exp=%h", ka, obs_a, fa(ka));
            end
        end
        n_cmp++;
        if (x_a !== 10'd3) begin
            n_bad++;
            $display("FAIL divider_x12 got=%0d exp=3", x_a);
        end
        $display("test_divider: 12 clk after release checked");
    endtask

    task automatic test_hsync();
        int low_clk;
        low_clk = 0;
        while (ka < 2 * 3200 + 20) begin
            tick_a();
            if (ka <= 3200 && hs_a === 1'b0) low_clk++;
            n_cmp++;
            if (obs_a !== fa(ka)) begin
                n_bad++;
                $display("FAIL hsync_line k=%0d got=%h exp=%h", ka, obs_a, fa(ka));
            end
        end
        n_cmp++;
        if (low_clk !== 384) begin
            n_bad++;
            $display("FAIL hsync_low_width got=%0d exp=384", low_clk);
        end
        $display("test_hsync: two lines checked, hsync low %0d clk", low_clk);
    endtask

    task automatic test_mid_reset();
        int target;
        target = ka + 3200 + 700 * 4 - (ka % 3200) + int'($urandom_range(0, 3));
        while (ka < target) begin
            tick_a();
            n_cmp++;
            if (obs_a !== fa(ka)) begin
                n_bad++;
                $display("FAIL mid_run k=%0d got=%h exp=%h", ka, obs_a, fa(ka));
            end
        end
        rst_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (obs_a !== fa(0)) begin
            n_bad++;
            $display("FAIL mid_reset got=%h exp=%h", obs_a, fa(0));
        end
        rst_a = 1'b0;
        ka = 0;
        for (int i = 0; i < 8; i++) begin
            tick_a();
            n_cmp++;
            if (obs_a !== fa(ka)) begin
                n_bad++;
                $display("FAIL mid_restart k=%0d got=%h exp=%h", ka, obs_a, fa(ka));
            end
        end
        $display("test_mid_reset: reset at pixel_x=700 then restart checked");
    endtask

    task automatic reset_b();
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (obs_b !== fb(0)) begin
            n_bad++;
            $display("FAIL reset_b got=%h exp=%h", obs_b, fb(0));
        end
        rst_b = 1'b0;
        kb = 0;
    endtask

    task automatic test_vertical();
        int vlow;
        int vid_bad;
        vlow = 0;
        vid_bad = 0;
        reset_b();
        while (kb < 480 + 8) begin
            tick_b();
            if (kb <= 480 && vs_b === 1'b0) vlow++;
            if (y_b >= 10'd5 && vid_b !== 1'b0) vid_bad++;
            n_cmp++;
            if (obs_b !== fb(kb)) begin
                n_bad++;
                $display("FAIL vertical k=%0d got=%h exp=%h", kb, obs_b, fb(kb));
            end
        end
        n_cmp++;
        if (vlow !== 48) begin
            n_bad++;
            $display("FAIL vsync_low_width got=%0d exp=48", vlow);
        end
        n_cmp++;
        if (vid_bad !== 0) begin
            n_bad++;
            $display("FAIL video_on_blank got=%0d exp=0", vid_bad);
        end
        $display("test_vertical: one frame checked, vsync low %0d clk", vlow);
    endtask

    task automatic test_frame_tick();
        int ticks;
        int tick_k;
        ticks = 0;
        tick_k = -1;
        reset_b();
        while (kb < 480) begin
            tick_b();
            if (ft_b === 1'b1) begin
                ticks++;
                tick_k = kb;
                n_cmp++;
                if (x_b !== 10'd11 || y_b !== 10'd9) begin
                    n_bad++;
                    $display("FAIL frame_tick_pos got=%0d,%0d exp=11,9", x_b, y_b);
                end
            end
        end
        n_cmp++;
        if (ticks !== 1 || tick_k !== 479) begin
            n_bad++;
            $display("FAIL frame_tick_count got=%0d@%0d exp=1@479", ticks, tick_k);
        end
        tick_b();
        n_cmp++;
        if (x_b !== 10'd0 || y_b !== 10'd0) begin
            n_bad++;
            $display("FAIL frame_wrap got=%0d,%0d exp=0,0", x_b, y_b);
        end
        $display("test_frame_tick: %0d frame_tick in one frame", ticks);
    endtask

    task automatic test_blink();
        int toggles;
        int exp_toggles;
        logic prev;
        toggles = 0;
        reset_b();
        prev = bl_b;
        while (kb < 61 * 480 + 4) begin
            tick_b();
            if (bl_b !== prev) toggles++;
            prev = bl_b;
            n_cmp++;
            if (obs_b !== fb(kb)) begin
                n_bad++;
                $display("FAIL blink_run k=%0d got=%h exp=%h", kb, obs_b, fb(kb));
            end
        end
`ifdef VGA_TIMING_BLINK_EN
        exp_toggles = 2;
`else
        exp_toggles = 0;
`endif
        n_cmp++;
        if (toggles !== exp_toggles || bl_b !== 1'b0) begin
            n_bad++;
            $display("FAIL blink_toggles got=%0d blink=%b exp=%0d blink=0", toggles, bl_b, exp_toggles);
        end
        $display("test_blink: 61 frames, blink toggled %0d times", toggles);
    endtask

    task automatic test_random_resets();
        int run;
        int hold;
        for (int it = 0; it < 8; it++) begin
            run = int'($urandom_range(1, 1000));
            hold = int'($urandom_range(1, 3));
            for (int i = 0; i < run; i++) begin
                tick_b();
                n_cmp++;
                if (obs_b !== fb(kb)) begin
                    n_bad++;
                    $display("FAIL rand_run k=%0d got=%h exp=%h", kb, obs_b, fb(kb));
                end
            end
            rst_b = 1'b1;
            repeat (hold) @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (obs_b !== fb(0)) begin
                n_bad++;
                $display("FAIL rand_reset got=%h exp=%h", obs_b, fb(0));
            end
            rst_b = 1'b0;
            kb = 0;
            $display("test_random_resets: run %0d clk, reset %0d clk", run, hold);
        end
        for (int i = 0; i < 6; i++) begin
            tick_b();
            n_cmp++;
            if (obs_b !== fb(kb)) begin
                n_bad++;
                $display("FAIL rand_restart k=%0d got=%h exp=%h", kb, obs_b, fb(kb));
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_divider();
        test_hsync();
        test_mid_reset();
        test_vertical();
        test_frame_tick();
        test_blink();
        test_random_resets();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have port: clk  input  1  system clock, 100 MHz; sole clock.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: p_tick  output  1  pixel-enable strobe, one clk wide, once every 4 clk.
REQ-004 SHALL have port: pixel_x  output  10  current horizontal count, 0..799.
REQ-005 SHALL have port: pixel_y  output  10  current vertical count, 0..524; the character generator consumes bits [8:0].
REQ-006 SHALL have port: hsync  output  1  horizontal sync, active-low.
REQ-007 SHALL have port: vsync  output  1  vertical sync, active-low.
REQ-008 SHALL have port: video_on_out  output  1  high inside the 640x480 visible area.
REQ-009 SHALL have port: frame_tick  output  1  one-clk pulse at each frame wrap.
REQ-010 SHALL have port: blink  output  1  slow square wave for the edit-field cursor.

Function
REQ-011 Pixel divider: 2-bit counter, increments every clk, wraps 3->0; p_tick SHALL be 1 exactly when the divider equals 3.
REQ-012 Horizontal counter h SHALL advance only on clk edges where p_tick=1; 799 SHALL wrap to 0.
REQ-013 Vertical counter v SHALL advance only on edges where p_tick=1 and h=799; 524 SHALL wrap to 0.
REQ-014 pixel_x SHALL equal h and pixel_y SHALL equal v, driven directly from the counter registers with zero latency.
REQ-015 hsync SHALL be registered and low exactly while h is in 656..751 inclusive; it SHALL change on the same edge as h.
REQ-016 vsync SHALL be registered and low exactly while v is in 490..491 inclusive; it SHALL change on the same edge as v.
REQ-017 video_on_out SHALL be high only when h<640 and v<480, decoded from the registered counters.
REQ-018 frame_tick SHALL be 1 for the single clk in which p_tick=1, h=799 and v=524, which is the edge on which both counters wrap.
REQ-019 All counter widths SHALL be exactly as declared, with no sign extension; comparisons SHALL be unsigned.
REQ-020 No output SHALL glitch between p_tick edges; all outputs SHALL be stable for 4 clk per pixel.

Reset
REQ-021 While reset=1 on a clk edge, the divider, h and v SHALL load 0, hsync and vsync SHALL load 1, and the blink state SHALL load 0.
REQ-022 During and immediately after reset, the output values SHALL be:
- p_tick=0
- pixel_x=0, pixel_y=0
- video_on_out=1
- frame_tick=0
- blink=0
REQ-023 On the first clk after reset deasserts, the divider SHALL read 1; the first p_tick SHALL occur on the 3rd clk after deassertion.
REQ-024 Reset asserted mid-frame or mid-sync SHALL abort immediately on the next edge and take priority over all counting.

Configuration
REQ-025 Macro VGA_TIMING_BLINK_EN SHALL control the blink feature as follows:
- Defined: a 5-bit frame counter increments on each frame_tick and wraps 29->0; blink SHALL toggle on the frame_tick where the counter wraps, giving a 30-frame half-period (about 0.5 s at 60 Hz).
- Undefined: the frame counter SHALL be absent and blink SHALL be constant 0.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-026 Reset, then 12 clk -> p_tick high exactly at clk 3, 7 and 11 after deassertion; pixel_x goes 0->1->2->3.
REQ-027 Run to h=655 then h=656 -> hsync falls on the edge where pixel_x becomes 656 and rises where pixel_x becomes 752; the hsync low period is 96 pixels (384 clk).
REQ-028 Run to v=489, h=799 -> vsync falls as pixel_y becomes 490 and rises as pixel_y becomes 492; video_on_out is 0 for all of v=480..524.
REQ-029 Run a full frame (800*525*4 = 1,680,000 clk) -> exactly one frame_tick, coincident with the pixel_x 799->0 and pixel_y 524->0 wrap.
REQ-030 With VGA_TIMING_BLINK_EN defined, run 61 frames -> blink toggles at frame_tick 30 and 60 and is 0 after frame 60; with the macro undefined, blink stays 0 throughout.
REQ-031 Assert reset for 1 clk at h=700, v=300 -> next edge shows pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on_out=1; counting restarts per REQ-023.
